fibonacci_seq_gen: RTL
======================

// Module: fibonacci_seq_gen
// PURPOSE
//  Parametrised Fibonacci sequence generator, successor of the fixed 8-bit free-running adder generator.
//  Adds WIDTH, programmable seeds, term count, valid/ready output handshake, and overflow detection.
//  Overflow handling is selectable: stop, or wrap mod 2^WIDTH.
//  The next term is summed by a WIDTH-stage ripple-carry adder chain; its carry-out is the overflow source.
//  Sits as a stimulus/data source feeding downstream arithmetic blocks.
// PARAMETERS
//  WIDTH     8  data width of each term
//  CNT_W     8  width of num_terms / term_idx
//  MODE_WRAP 0  0: stop before the first overflowed term; 1: emit terms mod 2^WIDTH and keep going
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous, active-low reset
//  start     in   1      begin a sequence; sampled only in IDLE
//  seed0     in   WIDTH  first term, latched on accepted start
//  seed1     in   WIDTH  second term, latched on accepted start
//  num_terms in   CNT_W  number of terms to emit, latched on accepted start
//  out_ready in   1      downstream accepts out this cycle
//  out       out  WIDTH  current term
//  out_valid out  1      out holds a valid term
//  term_idx  out  CNT_W  index of current term (0-based)
//  busy      out  1      1 in RUN
//  done      out  1      one-cycle pulse when a sequence ends
//  overflow  out  1      sticky per sequence; cleared on next accepted start
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE; out=0, out_valid=0, term_idx=0, busy=0, done=0, overflow=0, internal a/b/cnt=0.
//    Asserting reset mid-sequence aborts it immediately; no done pulse.
//  States: IDLE, RUN, DONE.
//  IDLE + start=1:
//    Latch a=seed0, b=seed1, n=num_terms; term_idx=0; overflow=0; flag ovf_b=0.
//    If n==0, go to DONE; else go to RUN.
//  RUN: busy=1, out_valid=1, out=a. Latency: start at edge k gives out_valid=1, out=seed0 after edge k+1.
//    out and term_idx are held stable while out_valid && !out_ready.
//  Accept = out_valid && out_ready. On accept:
//    If term_idx==n-1, go to DONE (out_valid=0).
//    Else if ovf_b==1 && MODE_WRAP==0, set overflow=1 and go to DONE. The wrapped term is never emitted.
//    Else a<=b; b<=a+b (low WIDTH bits); ovf_b<=carry-out of a+b; term_idx++.
//      If MODE_WRAP==1 and the promoted b had ovf_b=1, set overflow=1.
//  Carry-out on a sum whose term is never reached (count exhausted first) is ignored.
//  DONE: done=1 for exactly one cycle, out_valid=0, busy=0; then go to IDLE. overflow holds until the next start.
//  start while in RUN or DONE is ignored; seeds and num_terms are not re-latched.
//  Seeds are unsigned. seed0 > seed1 is legal. No overflow check is applied to the seeds themselves.
// TESTING (WIDTH=8 unless noted)
//  1 seeds 0,1, n=14, ready=1:
//    out=0,1,1,2,3,5,8,13,21,34,55,89,144,233 on consecutive cycles; done pulse; overflow=0.
//  2 seeds 0,1, n=20, MODE_WRAP=0:
//    14 terms ending at 233, then stop (144+233=377 carries); overflow=1; done pulse; term 377 never valid.
//  3 seeds 0,1, n=16, MODE_WRAP=1:
//    ...,144,233,121,98; overflow=1 once 121 is emitted; done after term_idx=15.
//  4 seeds 3,4, n=6, out_ready toggled 1,0,0,1,...:
//    exactly 3,4,7,11,18,29 accepted; out stable during stalls; no skips or duplicates.
//  5 n=0:
//    done pulse on the cycle after start; out_valid never 1.
//    start pulsed during RUN of another sequence is ignored.
//  6 reset=0 at term_idx=5 of test 1:
//    all outputs 0 immediately, asynchronously; after release, new start with seeds 2,2
//    gives 2,2,4,6,... from term_idx=0.

Source files
------------

// File: rtl/fibonacci_seq_gen.sv
// Fibonacci term source with programmable seeds and term count, a valid/ready output
// handshake, and overflow handling selectable between stop and wrap.
module fibonacci_seq_gen #(
   parameter int WIDTH     = 8,
   parameter int CNT_W     = 8,
   parameter int MODE_WRAP = 0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_seed0,
   input  logic [WIDTH-1:0] i_seed1,
   input  logic [CNT_W-1:0] i_num_terms,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_out,
   output logic             o_out_valid,
   output logic [CNT_W-1:0] o_term_idx,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_overflow
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [CNT_W-1:0] r_n;
   logic [CNT_W-1:0] r_idx;
   logic             r_ovf_b;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_overflow;

   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;
   logic             w_accept;
   logic             w_last;

   // Ripple-carry chain; the final carry flags that b's successor no longer fits.
   assign w_carry[0] = 1'b0;
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rca
         assign w_sum[gi]       = r_a[gi] ^ r_b[gi] ^ w_carry[gi];
         assign w_carry[gi + 1] = (r_a[gi] & r_b[gi]) | (w_carry[gi] & (r_a[gi] ^ r_b[gi]));
      end
   endgenerate

   assign w_accept = r_valid & i_out_ready;
   assign w_last   = (r_idx == (r_n - CNT_W'(1)));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_n        <= '0;
         r_idx      <= '0;
         r_ovf_b    <= 1'b0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_a        <= i_seed0;
                  r_b        <= i_seed1;
                  r_n        <= i_num_terms;
                  r_idx      <= '0;
                  r_ovf_b    <= 1'b0;
                  r_overflow <= 1'b0;
                  if (i_num_terms == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_RUN;
                     r_valid <= 1'b1;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  if (w_last || (r_ovf_b && (MODE_WRAP == 0))) begin
                     // Stop mode never promotes a carried term into a.
                     if (!w_last) r_overflow <= 1'b1;
                     r_state <= S_DONE;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_a     <= r_b;
                     r_b     <= w_sum;
                     r_ovf_b <= w_carry[WIDTH];
                     r_idx   <= r_idx + CNT_W'(1);
                     if (r_ovf_b) r_overflow <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_out       = r_a;
   assign o_out_valid = r_valid;
   assign o_term_idx  = r_idx;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_overflow  = r_overflow;

endmodule
